// File: rtl/trax_move_parser.sv
// trax_move_parser: parses ASCII Trax moves ("B12\") and colour lines ("-W"/"-B")
// from the UART byte stream into registered, single-cycle output pulses.
module trax_move_parser #(
    parameter int COORD_W        = 10,
    parameter int MAX_ROW_DIGITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [2*COORD_W+1:0]   move_out,
    output logic                   move_valid,
    output logic                   color,
    output logic                   color_valid,
    output logic                   parse_error
);
    localparam int CW = $clog2(MAX_ROW_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ROW_DIGITS);

    typedef enum logic [2:0] {IDLE, COLOR, CTERM, ROW0, ROW, TERM, DRAIN} state_t;

    state_t               state, state_n;
    logic [COORD_W-1:0]   col, col_n, row, row_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [1:0]           tile, tile_n;
    logic                 pend, pend_n, color_n;
    logic [2*COORD_W+1:0] move_n;
    logic                 mv_n, cv_n, pe_n;
    logic                 is_digit, is_nl, is_tile;
    logic [1:0]           tile_code;

    assign is_digit  = rx_byte >= 8'h30 && rx_byte <= 8'h39;
    assign is_nl     = rx_byte == 8'h0A;
    assign tile_code = rx_byte == 8'h2B ? 2'b01 : rx_byte == 8'h2F ? 2'b10 :
                       rx_byte == 8'h5C ? 2'b11 : 2'b00;
    assign is_tile   = tile_code != 2'b00;

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        cnt_n   = cnt;
        tile_n  = tile;
        pend_n  = pend;
        color_n = color;
        move_n  = move_out;
        mv_n    = 1'b0;
        cv_n    = 1'b0;
        pe_n    = 1'b0;
        // carriage returns are invisible in every state
        if (rx_valid && rx_byte != 8'h0D) begin
            case (state)
                IDLE: begin
                    if (rx_byte >= 8'h40 && rx_byte <= 8'h5A) begin
                        col_n   = COORD_W'(rx_byte - 8'h40);
                        state_n = ROW0;
                    end else if (rx_byte == 8'h2D) state_n = COLOR;
                    else if (!is_nl) state_n = DRAIN;
                end
                COLOR: begin
                    pend_n  = rx_byte == 8'h42;
                    state_n = (rx_byte == 8'h42 || rx_byte == 8'h57) ? CTERM : DRAIN;
                end
                CTERM: begin
                    if (is_nl) begin
                        color_n = pend;
                        cv_n    = 1'b1;
                        state_n = IDLE;
                    end else state_n = DRAIN;
                end
                ROW0: begin
                    if (is_digit) begin
                        row_n   = COORD_W'(rx_byte[3:0]);
                        cnt_n   = CW'(1);
                        state_n = ROW;
                    end else state_n = DRAIN;
                end
                ROW: begin
                    if (is_digit && cnt < MAX_CNT) begin
                        row_n = (row << 3) + (row << 1) + COORD_W'(rx_byte[3:0]);
                        cnt_n = cnt + 1'b1;
                    end else if (is_tile) begin
                        tile_n  = tile_code;
                        state_n = TERM;
                    end else state_n = DRAIN;
                end
                TERM: begin
                    if (is_nl) begin
                        move_n  = {tile, col, row};
                        mv_n    = 1'b1;
                        state_n = IDLE;
                    end else state_n = DRAIN;
                end
                default: begin
                    if (is_nl) begin
                        pe_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            cnt         <= '0;
            tile        <= '0;
            pend        <= 1'b0;
            color       <= 1'b0;
            move_out    <= '0;
            move_valid  <= 1'b0;
            color_valid <= 1'b0;
            parse_error <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            cnt         <= cnt_n;
            tile        <= tile_n;
            pend        <= pend_n;
            color       <= color_n;
            move_out    <= move_n;
            move_valid  <= mv_n;
            color_valid <= cv_n;
            parse_error <= pe_n;
        end
    end
endmodule
